// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 burst memory responder backed by an internal word-addressed dual-port RAM
module axi_ram_slave #(
  parameter int ID_W       = 1,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);
  localparam int B  = $clog2(DATA_W/8);
  localparam int SW = DATA_W/8;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  wstate_t ws, ws_n;
  rstate_t rs, rs_n;
  logic [MEM_ADDR_W-1:0] widx, ridx;
  logic [7:0] wlen, wcnt, rlen, rcnt;
  logic wfix, rfix, werr;
  logic aw_hs, w_hs, w_end, ar_hs, r_hs, r_end;
  logic unused_ok;
  // address bits outside the word index and the WRAP/INCR distinction are deliberately ignored
  assign unused_ok = ^{axi_awaddr, axi_araddr, axi_awburst, axi_arburst};
  // write FSM: next state and handshake outputs decoded from the current state
  always_comb begin
    axi_awready = (ws == W_IDLE);
    axi_wready  = (ws == W_DATA);
    axi_bvalid  = (ws == W_RESP);
    axi_bresp   = {werr, 1'b0};
    aw_hs       = axi_awvalid & axi_awready;
    w_hs        = axi_wvalid & axi_wready;
    w_end       = (wcnt == wlen);
    ws_n        = (ws == W_IDLE && aw_hs)          ? W_DATA :
                  (ws == W_DATA && w_hs && w_end)  ? W_RESP :
                  (ws == W_RESP && axi_bready)     ? W_IDLE : ws;
  end
  // write FSM state register; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) ws <= W_IDLE;
    else ws <= ws_n;
  // write burst context: latched on AW, advanced per W beat; wlast misplacement flags SLVERR
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      axi_bid <= '0;
      widx    <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      wfix    <= 1'b0;
      werr    <= 1'b0;
    end else if (aw_hs) begin
      axi_bid <= axi_awid;
      widx    <= axi_awaddr[MEM_ADDR_W+B-1:B];
      wlen    <= axi_awlen;
      wcnt    <= '0;
      wfix    <= (axi_awburst == 2'b00);
      werr    <= 1'b0;
    end else if (w_hs) begin
      widx    <= wfix ? widx : widx + MEM_ADDR_W'(1);
      wcnt    <= wcnt + 8'd1;
      werr    <= werr | (axi_wlast != w_end);
    end
  // RAM write port with byte enables; contents survive reset
  always_ff @(posedge clk)
    if (w_hs)
      for (int i = 0; i < SW; i++)
        if (axi_wstrb[i]) mem[widx][8*i +: 8] <= axi_wdata[8*i +: 8];
  // read FSM: next state and handshake outputs decoded from the current state
  always_comb begin
    axi_arready = (rs == R_IDLE);
    axi_rvalid  = (rs == R_DATA);
    r_end       = (rcnt == rlen);
    axi_rlast   = (rs == R_DATA) && r_end;
    axi_rresp   = 2'b00;
    ar_hs       = axi_arvalid & axi_arready;
    r_hs        = axi_rvalid & axi_rready;
    rs_n        = (rs == R_IDLE && ar_hs) ? R_FETCH :
                  (rs == R_FETCH)         ? R_DATA :
                  r_hs                    ? (r_end ? R_IDLE : R_FETCH) : rs;
  end
  // read FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) rs <= R_IDLE;
    else rs <= rs_n;
  // read burst context: latched on AR, advanced on each accepted R beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      axi_rid <= '0;
      ridx    <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rfix    <= 1'b0;
    end else if (ar_hs) begin
      axi_rid <= axi_arid;
      ridx    <= axi_araddr[MEM_ADDR_W+B-1:B];
      rlen    <= axi_arlen;
      rcnt    <= '0;
      rfix    <= (axi_arburst == 2'b00);
    end else if (r_hs && !r_end) begin
      ridx    <= rfix ? ridx : ridx + MEM_ADDR_W'(1);
      rcnt    <= rcnt + 8'd1;
    end
  // registered RAM read in FETCH; rdata then holds through any R stall, old data wins on collision
  always_ff @(posedge clk or posedge rst)
    if (rst) axi_rdata <= '0;
    else if (rs == R_FETCH) axi_rdata <= mem[ridx];
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed self-checking bench for axi_ram_slave
module tb_axi_ram_slave;
  logic        clk = 1'b0, rst = 1'b1;
  logic        awid = 1'b0, awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bid, bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arid = 1'b0, arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        rid, rlast, rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  int checks = 0, errors = 0;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awburst(awburst),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arburst(arburst),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_rvalid(rvalid), .axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic id);
    int n = 0;
    awaddr = a; awlen = l; awburst = b; awid = id; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin n++; @(negedge clk); end
    chk("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic id,
                    input logic [31:0] base, input logic [3:0] s, input int lastpos);
    aw_send(a, l, b, id);
    for (int i = 0; i <= int'(l); i++) begin
      int n = 0;
      wdata = base + i; wstrb = s; wlast = (i == lastpos); wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 50) begin n++; @(negedge clk); end
      chk("w_ready", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_chk(input logic [1:0] resp, input logic id, input int hold);
    int n = 0;
    bready = 1'b0;
    @(negedge clk);
    while (!bvalid && n < 50) begin n++; @(negedge clk); end
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_id", bid, id);
      chk("b_hold_resp", bresp, resp);
      chk("b_hold_awready", awready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_single", bvalid, 0);
    chk("b_awready_back", awready, 1);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic id);
    int n = 0;
    araddr = a; arlen = l; arburst = b; arid = id; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    chk("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_beats(input logic [7:0] l, input logic id, input logic [31:0] base, input bit rnd);
    int beat = 0, n = 0;
    rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (beat <= int'(l) && n < 400) begin
      n++;
      @(negedge clk);
      if (rvalid) begin
        chk("r_data", rdata, base + beat);
        chk("r_last", rlast, beat == int'(l));
        chk("r_id", rid, id);
        chk("r_resp", rresp, 0);
        if (rready) beat++;
      end
      tick();
      if (rnd) rready = 1'($urandom_range(0, 1));
    end
    rready = 1'b0;
    chk("r_beat_count", beat, int'(l) + 1);
    chk("r_idle_arready", arready, 1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic id,
                    input logic [31:0] base, input bit rnd);
    ar_send(a, l, b, id);
    r_beats(l, id, base, rnd);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();
    // INCR burst write/read with first-beat latency
    wr(32'h100, 3, 2'b01, 1'b1, 32'd1, 4'hF, 3);
    b_chk(2'b00, 1'b1, 0);
    ar_send(32'h100, 3, 2'b01, 1'b1);
    chk("lat_fetch_rvalid", rvalid, 0);
    tick();
    chk("lat_data_rvalid", rvalid, 1);
    r_beats(3, 1'b1, 32'd1, 1'b0);
    // partial strobe merge
    wr(32'h40, 0, 2'b01, 1'b0, 32'hAABBCCDD, 4'hF, 0);
    b_chk(2'b00, 1'b0, 0);
    wr(32'h40, 0, 2'b01, 1'b0, 32'h11223344, 4'b0101, 0);
    b_chk(2'b00, 1'b0, 0);
    rd(32'h40, 0, 2'b01, 1'b0, 32'hAA22CC44, 1'b0);
    // FIXED write keeps the last beat
    wr(32'h20, 2, 2'b00, 1'b1, 32'd5, 4'hF, 2);
    b_chk(2'b00, 1'b1, 0);
    rd(32'h20, 0, 2'b01, 1'b1, 32'd7, 1'b0);
    // index wrap at the top of the RAM
    wr(32'hFFFC, 1, 2'b01, 1'b0, 32'hA, 4'hF, 1);
    b_chk(2'b00, 1'b0, 0);
    rd(32'hFFFC, 1, 2'b01, 1'b0, 32'hA, 1'b0);
    rd(32'h0, 0, 2'b01, 1'b0, 32'hB, 1'b0);
    // early wlast: all beats written, SLVERR, B held under back-pressure
    wr(32'h200, 2, 2'b01, 1'b1, 32'd9, 4'hF, 1);
    b_chk(2'b10, 1'b1, 5);
    rd(32'h200, 2, 2'b01, 1'b1, 32'd9, 1'b0);
    // missing wlast on a single-beat burst
    wr(32'h280, 0, 2'b01, 1'b0, 32'h77, 4'hF, 8);
    b_chk(2'b10, 1'b0, 0);
    // random rready read concurrent with an 8-beat write elsewhere
    wr(32'h300, 7, 2'b01, 1'b0, 32'h30, 4'hF, 7);
    b_chk(2'b00, 1'b0, 0);
    fork
      rd(32'h300, 7, 2'b01, 1'b0, 32'h30, 1'b1);
      begin
        wr(32'h400, 7, 2'b10, 1'b1, 32'h40, 4'hF, 7);
        b_chk(2'b00, 1'b1, 0);
      end
    join
    rd(32'h400, 7, 2'b01, 1'b1, 32'h40, 1'b0);
    // reset in the middle of a write burst
    aw_send(32'h500, 3, 2'b01, 1'b1);
    wdata = 32'hDEAD; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    tick();
    tick();
    wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_awready", awready, 1);
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    wr(32'h500, 3, 2'b01, 1'b0, 32'h50, 4'hF, 3);
    b_chk(2'b00, 1'b0, 0);
    rd(32'h500, 3, 2'b01, 1'b0, 32'h50, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
AXI4 memory responder: accepts INCR/FIXED bursts on AW/W/B and AR/R from an AXI master and services them from an internal word-addressed RAM. It is the slave end of the DDR AXI master interface, used as the DDR stand-in for simulation and for small FPGA builds. Read and write paths are independent FSMs sharing a dual-port RAM.

Parameters:
ID_W, 1, AXI ID width
ADDR_W, 32, AXI address width
DATA_W, 32, data width; power of two, 32..256
MEM_ADDR_W, 14, RAM depth = 2**MEM_ADDR_W words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
axi_awid  in  ID_W  write ID
axi_awaddr  in  ADDR_W  write byte address
axi_awlen  in  8  beats-1
axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP treated as INCR
axi_awvalid  in  1  AW valid
axi_awready  out  1  AW ready
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte enables
axi_wlast  in  1  last beat
axi_wvalid  in  1  W valid
axi_wready  out  1  W ready
axi_bid  out  ID_W  echo of awid
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bvalid  out  1  B valid
axi_bready  in  1  B ready
axi_arid  in  ID_W  read ID
axi_araddr  in  ADDR_W  read byte address
axi_arlen  in  8  beats-1
axi_arburst  in  2  as awburst
axi_arvalid  in  1  AR valid
axi_arready  out  1  AR ready
axi_rid  out  ID_W  echo of arid
axi_rdata  out  DATA_W  read data
axi_rresp  out  2  always 00
axi_rlast  out  1  last beat
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready

Behaviour:
- Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00, bid/rid/rdata=0; both FSMs return to IDLE. RAM contents are not cleared. A reset mid-burst abandons the burst with no response.
- Sizes: the block has no size ports. Every beat is a full DATA_W word.
- Word index = addr[MEM_ADDR_W+B-1:B], with B=log2(DATA_W/8). Low B bits and bits above the index are ignored, so addresses wrap modulo the RAM size.
- INCR bursts add 1 to the word index per beat, wrapping at 2**MEM_ADDR_W. FIXED bursts hold the index.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id/index/len/burst, clear beat count and error flag, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb at the current index.
  - wlast=1 before count==len, or wlast=0 at count==len, sets the error flag; the beat is still written.
  - At count==len, go to W_RESP. Any remaining beats stay stalled (wready=0).
  - W_RESP: bvalid=1, bresp=10 if the error flag is set, else 00. Hold until bready, then go to W_IDLE.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch id/index/len/burst and go to R_FETCH.
  - R_FETCH: issue a registered RAM read (1-cycle latency), go to R_DATA.
  - R_DATA: rvalid=1; rdata, rid and rlast (count==len) are held stable while rready=0.
  - On R handshake: if last, go to R_IDLE; otherwise advance the index and go to R_FETCH.
  - First rvalid is 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles.
- Simultaneous read and write to the same word in the same cycle returns the old data.
- Only one outstanding burst per direction. Read and write may proceed concurrently.

Test Plan:
- Write INCR len=3 at 0x100, data 1..4, wstrb=F -> single bvalid, bresp=00, bid=awid. Read INCR len=3 at 0x100 -> 1,2,3,4, rlast only on the 4th beat, first rvalid 2 cycles after AR.
- Partial strobe: write 0xAABBCCDD to 0x40, then 0x11223344 with wstrb=0101 -> read of 0x40 returns 0xAA22CC44.
- FIXED write len=2 to 0x20 with data 5,6,7 -> read returns 7. INCR read starting at the last word wraps -> second beat comes from word 0.
- wlast asserted on beat 1 of len=2 -> all 3 beats written, bresp=10. bready held low 5 cycles -> bvalid, bid and bresp stable, awready=0 throughout.
- rready toggled randomly during a len=7 read -> no beat lost or duplicated, rdata stable while stalled. Concurrent 8-beat write elsewhere completes correctly.
- Reset asserted mid write burst -> next cycle awready=1, wready=0, bvalid=0. A new burst then completes normally.
